// File: rtl/tbird_sweep_ctrl.sv
// tbird_sweep_ctrl: parametrised turn-signal sequencer (outward sweep per side plus hazard flash).
//
// A free-running prescaler produces a one-cycle tick every TICK_DIV clocks. The FSM and the
// phase counter only move on a tick. The lamp outputs are registered and change on the same
// edge as the state.
//
// Parameters:
//   LAMPS    - lamps per side, 1..16
//   TICK_DIV - clk cycles per sequencing step, >= 1 (1 = step every cycle, simulation only)
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-low reset
//   left    in   left-turn request (level)
//   right   in   right-turn request (level)
//   hazard  in   hazard request (level)
//   brake   in   brake lamp request, only when TBIRD_BRAKE_EN is defined
//   lamps_l out  left lamps, bit 0 innermost
//   lamps_r out  right lamps, bit 0 innermost
//   active  out  high whenever the FSM is not idle
//
// Build option: define TBIRD_BRAKE_EN to add the brake input. While brake is high, each side
// that is not sweeping shows all ones (ignored during hazard). Without the macro the block
// behaves as if brake were tied low.

module tbird_sweep_ctrl #(
  parameter int unsigned LAMPS    = 3,
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
`ifdef TBIRD_BRAKE_EN
  input  logic             brake,
`endif
  output logic [LAMPS-1:0] lamps_l,
  output logic [LAMPS-1:0] lamps_r,
  output logic             active
);

  // Prescaler width is at least one bit so TICK_DIV = 1 still yields a legal vector.
  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  // Phase counter spans 0..LAMPS.
  localparam int unsigned PhW = $clog2(LAMPS + 1);
  localparam logic [PhW-1:0] PhMax = PhW'(LAMPS);

  typedef enum logic [1:0] {
    StIdle,
    StLeft,
    StRight,
    StHazard
  } state_e;

  state_e          state_q, state_d;
  logic [PhW-1:0]  ph_q, ph_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;

  logic [LAMPS-1:0] lamps_l_q, lamps_l_d;
  logic [LAMPS-1:0] lamps_r_q, lamps_r_d;
  logic [LAMPS-1:0] therm;
  logic             brake_req;

`ifdef TBIRD_BRAKE_EN
  assign brake_req = brake;
`else
  assign brake_req = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) begin
      cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    if (tick) begin
      if (ph_q == '0) begin
        // Requests are only looked at here, so a sweep always runs to its all-off step.
        if (hazard || (left && right)) begin
          state_d = StHazard;
          ph_d    = PhW'(1);
        end else if (left) begin
          state_d = StLeft;
          ph_d    = PhW'(1);
        end else if (right) begin
          state_d = StRight;
          ph_d    = PhW'(1);
        end else begin
          state_d = StIdle;
          ph_d    = '0;
        end
      end else begin
        unique case (state_q)
          StLeft, StRight: begin
            // ph == LAMPS leads to the all-off step with the state held.
            if (ph_q >= PhMax) begin
              ph_d = '0;
            end else begin
              ph_d = ph_q + 1'b1;
            end
          end
          StHazard: begin
            ph_d = '0;
          end
          default: begin
            // Idle never carries a non-zero phase; recover to a clean idle.
            state_d = StIdle;
            ph_d    = '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lamp decode from the next state so lamps change on the same edge as the FSM.
  // ---------------------------------------------------------------------------
  always_comb begin
    therm = '0;
    for (int i = 0; i < int'(LAMPS); i++) begin
      therm[i] = (i < int'(ph_d));
    end
  end

  always_comb begin
    lamps_l_d = '0;
    lamps_r_d = '0;
    unique case (state_d)
      StLeft:   lamps_l_d = therm;
      StRight:  lamps_r_d = therm;
      StHazard: begin
        if (ph_d != '0) begin
          lamps_l_d = '1;
          lamps_r_d = '1;
        end
      end
      default: begin
        lamps_l_d = '0;
        lamps_r_d = '0;
      end
    endcase

    // Brake lights the non-sweeping side(s); it never touches state or phase.
    if (brake_req) begin
      case (state_d)
        StIdle: begin
          lamps_l_d = '1;
          lamps_r_d = '1;
        end
        StLeft:  lamps_r_d = '1;
        StRight: lamps_l_d = '1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      ph_q      <= '0;
      cnt_q     <= '0;
      lamps_l_q <= '0;
      lamps_r_q <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      lamps_l_q <= lamps_l_d;
      lamps_r_q <= lamps_r_d;
    end
  end

  assign lamps_l = lamps_l_q;
  assign lamps_r = lamps_r_q;
  assign active  = (state_q != StIdle);

endmodule

// File: tb/tb_tbird_sweep_ctrl.sv
// tb_tbird_sweep_ctrl: self-checking bench for tbird_sweep_ctrl.
//
// Two instances share the stimulus: A (LAMPS=3, TICK_DIV=4) and B (LAMPS=1, TICK_DIV=1).
// The reference model describes each side's output as a position within a sequence of
// patterns (a sweep is LAMPS+1 patterns, a hazard flash 2, idle 1) and advances that position
// once per TICK_DIV cycles. Define TBIRD_BRAKE_EN to also exercise the brake input.

module tb_tbird_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       hazard = 1'b0;
  logic       brake = 1'b0;
  logic [2:0] a_l, a_r;
  logic       a_act;
  logic [0:0] b_l, b_r;
  logic       b_act;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tbird_sweep_ctrl #(.LAMPS(3), .TICK_DIV(4)) u_a (
    .clk    (clk),
    .reset  (reset),
    .left   (left),
    .right  (right),
    .hazard (hazard),
`ifdef TBIRD_BRAKE_EN
    .brake  (brake),
`endif
    .lamps_l(a_l),
    .lamps_r(a_r),
    .active (a_act)
  );

  tbird_sweep_ctrl #(.LAMPS(1), .TICK_DIV(1)) u_b (
    .clk    (clk),
    .reset  (reset),
    .left   (left),
    .right  (right),
    .hazard (hazard),
`ifdef TBIRD_BRAKE_EN
    .brake  (brake),
`endif
    .lamps_l(b_l),
    .lamps_r(b_r),
    .active (b_act)
  );

  // ---------------------------------------------------------------------------
  // Reference model. Modes: 0 idle, 1 left, 2 right, 3 hazard. step counts 1..seq_len.
  // ---------------------------------------------------------------------------
  int m_mode[2] = '{0, 0};
  int m_step[2] = '{1, 1};
  int m_cnt[2]  = '{0, 0};
  bit m_rst     = 1'b1;
  bit m_brake   = 1'b0;

  function automatic int n_lamps(int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic int div_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int seq_len(int mode, int l);
    if (mode == 1 || mode == 2) return l + 1;
    if (mode == 3) return 2;
    return 1;
  endfunction

  // Pattern shown on one side; 'sweep_mode' is the mode that sweeps this side.
  function automatic logic [15:0] side_exp(int mode, int step, int l, int sweep_mode,
                                           bit brk, bit rst);
    logic [15:0] mask;
    logic [15:0] v;
    mask = 16'((32'd1 << l) - 1);
    v = 16'd0;
    if (rst) return 16'd0;
    if (mode == sweep_mode && step <= l) v = 16'((32'd1 << step) - 1);
    if (mode == 3 && step == 1) v = mask;
    if (brk && mode != 3 && mode != sweep_mode) v = mask;
    return v;
  endfunction

  always @(posedge clk) begin
    bit brk_now;
`ifdef TBIRD_BRAKE_EN
    brk_now = brake;
`else
    brk_now = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_cnt[k]  = 0;
        m_mode[k] = 0;
        m_step[k] = 1;
      end else if (m_cnt[k] == div_of(k) - 1) begin
        m_cnt[k] = 0;
        m_step[k] = m_step[k] + 1;
        if (m_step[k] > seq_len(m_mode[k], n_lamps(k))) begin
          m_mode[k] = (hazard || (left && right)) ? 3 : left ? 1 : right ? 2 : 0;
          m_step[k] = 1;
        end
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
      end
    end
    m_rst   = !reset;
    m_brake = brk_now;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_lamps_l", 16'(a_l), side_exp(m_mode[0], m_step[0], 3, 1, m_brake, m_rst));
      chk("a_lamps_r", 16'(a_r), side_exp(m_mode[0], m_step[0], 3, 2, m_brake, m_rst));
      chk("a_active", 16'(a_act), 16'(!m_rst && m_mode[0] != 0));
      chk("b_lamps_l", 16'(b_l), side_exp(m_mode[1], m_step[1], 1, 1, m_brake, m_rst));
      chk("b_lamps_r", 16'(b_r), side_exp(m_mode[1], m_step[1], 1, 2, m_brake, m_rst));
      chk("b_active", 16'(b_act), 16'(!m_rst && m_mode[1] != 0));
    end
  end

  task automatic pin_a(input string name, input logic [2:0] l, input logic [2:0] r,
                       input logic act);
    chk({name, "_l"}, 16'(a_l), 16'(l));
    chk({name, "_r"}, 16'(a_r), 16'(r));
    chk({name, "_act"}, 16'(a_act), 16'(act));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    pin_a("reset_state", 3'b000, 3'b000, 1'b0);
    chk("b_reset_act", 16'(b_act), 16'd0);

    // Release reset with left held; A's first tick lands on the 4th edge.
    reset = 1'b1;
    left  = 1'b1;
    @(negedge clk);
    chk("b_left_step1", 16'(b_l), 16'd1);
    @(negedge clk);
    chk("b_left_off", 16'(b_l), 16'd0);
    @(negedge clk);
    pin_a("pre_first_tick", 3'b000, 3'b000, 1'b0);
    @(negedge clk);
    pin_a("left_1", 3'b001, 3'b000, 1'b1);
    repeat (4) @(negedge clk);
    pin_a("left_2", 3'b011, 3'b000, 1'b1);
    repeat (4) @(negedge clk);
    pin_a("left_3", 3'b111, 3'b000, 1'b1);
    repeat (4) @(negedge clk);
    pin_a("left_off", 3'b000, 3'b000, 1'b1);
    repeat (4) @(negedge clk);
    pin_a("left_again", 3'b001, 3'b000, 1'b1);

    // Add right mid-sweep: left sweep finishes, then left&right decodes to hazard.
    right = 1'b1;
    repeat (4) @(negedge clk);
    pin_a("mid_2", 3'b011, 3'b000, 1'b1);
    repeat (4) @(negedge clk);
    pin_a("mid_3", 3'b111, 3'b000, 1'b1);
    repeat (4) @(negedge clk);
    pin_a("mid_off", 3'b000, 3'b000, 1'b1);
    repeat (4) @(negedge clk);
    pin_a("haz_on", 3'b111, 3'b111, 1'b1);
    repeat (4) @(negedge clk);
    pin_a("haz_off", 3'b000, 3'b000, 1'b1);
    repeat (4) @(negedge clk);
    pin_a("haz_on2", 3'b111, 3'b111, 1'b1);
    left  = 1'b0;
    right = 1'b0;
    repeat (4) @(negedge clk);
    pin_a("haz_tail", 3'b000, 3'b000, 1'b1);
    repeat (4) @(negedge clk);
    pin_a("back_idle", 3'b000, 3'b000, 1'b0);

    // Randomised phase: slowly varying levels, short pulses, occasional reset and brake.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) left = ~left;
      if ($urandom_range(0, 15) == 0) right = ~right;
      if ($urandom_range(0, 39) == 0) hazard = ~hazard;
      if ($urandom_range(0, 9) == 0) brake = ~brake;
      reset = ($urandom_range(0, 79) != 0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
